time_set_unit: RTL and testbench

- Parametrised successor to the clock's hours/minutes set logic for the digital alarm clock.
- Captures the running time on entry to adjust mode and edits hours, minutes or seconds with up/down buttons.
- Single press steps once; a held button auto-repeats. Hour modulus is configurable.
- Outputs BCD digits for the display path and a one-cycle commit pulse to Time_Mode / alarm register on exit.

---
 rtl/time_set_unit.sv | 182 ++++++++++++++++++
 tb/tb_time_set_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_unit.sv
// Hours/minutes/seconds set unit: captures the running time on adjust entry,
// steps the selected field with press/auto-repeat and pulses commit on exit.
module time_set_unit #(
    parameter int HOUR_MOD      = 24,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adjust,
    input  logic [1:0] sel_field,
    input  logic       inc,
    input  logic       dec,
    input  logic [4:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    output logic [1:0] H1,
    output logic [3:0] H2,
    output logic [2:0] M1,
    output logic [3:0] M2,
    output logic [2:0] S1,
    output logic [3:0] S2,
    output logic       commit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int CW = $clog2(RMAX + 1);

    localparam logic [CW-1:0] DLY   = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER   = CW'(REPEAT_PERIOD);
    localparam logic [4:0]    H_MOD = 5'(HOUR_MOD);
    localparam logic [4:0]    H_MAX = 5'(HOUR_MOD - 1);
    localparam logic [5:0]    MS_MAX = 6'd59;

    state_t        state_q, state_d;
    logic [4:0]    h_q, h_d;
    logic [5:0]    m_q, m_d;
    logic [5:0]    s_q, s_d;
    logic          adj_q, adj_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          arm_q, arm_d;
    logic          rep_q, rep_d;

    logic          up;
    logic          dn;
    logic          step_en;
    logic [CW-1:0] cnt_inc;

    assign up      = inc & ~dec;
    assign dn      = dec & ~inc;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        adj_d   = adjust;
        up_d    = up;
        dn_d    = dn;
        sel_d   = sel_field;
        cnt_d   = cnt_q;
        arm_d   = arm_q;
        rep_d   = rep_q;
        step_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                arm_d = 1'b0;
                rep_d = 1'b0;
                if (adjust && !adj_q) begin
                    h_d     = (load_h >= H_MOD)  ? 5'd0 : load_h;
                    m_d     = (load_m > MS_MAX)  ? 6'd0 : load_m;
                    s_d     = (load_s > MS_MAX)  ? 6'd0 : load_s;
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (!adjust) begin
                    state_d = COMMIT;
                    cnt_d   = '0;
                    arm_d   = 1'b0;
                    rep_d   = 1'b0;
                end else if ((up && !up_q) || (dn && !dn_q)) begin
                    step_en = 1'b1;
                    cnt_d   = '0;
                    arm_d   = 1'b1;
                    rep_d   = 1'b0;
                end else if (!(up || dn)) begin
                    cnt_d = '0;
                    rep_d = 1'b0;
                end else if (sel_field != sel_q) begin
                    // a held button cannot drag repeat into a new field
                    cnt_d = '0;
                    arm_d = 1'b0;
                    rep_d = 1'b0;
                end else if (arm_q) begin
                    if (cnt_inc == (rep_q ? PER : DLY)) begin
                        step_en = 1'b1;
                        cnt_d   = '0;
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (step_en) begin
            unique case (sel_field)
                2'd0: begin
                    if (up) h_d = (h_q >= H_MAX) ? 5'd0 : h_q + 5'd1;
                    else    h_d = (h_q == 5'd0) ? H_MAX : h_q - 5'd1;
                end
                2'd1: begin
                    if (up) m_d = (m_q >= MS_MAX) ? 6'd0 : m_q + 6'd1;
                    else    m_d = (m_q == 6'd0) ? MS_MAX : m_q - 6'd1;
                end
                2'd2: begin
                    if (up) s_d = (s_q >= MS_MAX) ? 6'd0 : s_q + 6'd1;
                    else    s_d = (s_q == 6'd0) ? MS_MAX : s_q - 6'd1;
                end
                2'd3: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            adj_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            sel_q   <= 2'd3;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            adj_q   <= adj_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
            rep_q   <= rep_d;
        end
    end

    assign H1     = 2'(h_q / 5'd10);
    assign H2     = 4'(h_q % 5'd10);
    assign M1     = 3'(m_q / 6'd10);
    assign M2     = 4'(m_q % 6'd10);
    assign S1     = 3'(s_q / 6'd10);
    assign S2     = 4'(s_q % 6'd10);
    assign commit = (state_q == COMMIT);

endmodule

// File: tb/tb_time_set_unit.sv
// Directed bench for time_set_unit: vector table plus hand sequences for
// async reset mid-repeat and a 12-hour instance.
module tb_time_set_unit;

    logic       clk;
    logic       rst;
    logic       adjust;
    logic [1:0] sel_field;
    logic       inc;
    logic       dec;
    logic [4:0] load_h;
    logic [5:0] load_m;
    logic [5:0] load_s;

    logic [1:0] H1, H1b;
    logic [3:0] H2, H2b;
    logic [2:0] M1, M1b;
    logic [3:0] M2, M2b;
    logic [2:0] S1, S1b;
    logic [3:0] S2, S2b;
    logic       commit, commitb;

    int checks   = 0;
    int failures = 0;

    time_set_unit #(
        .HOUR_MOD(24), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) u_dut (
        .clk(clk), .rst(rst), .adjust(adjust), .sel_field(sel_field),
        .inc(inc), .dec(dec), .load_h(load_h), .load_m(load_m),
        .load_s(load_s), .H1(H1), .H2(H2), .M1(M1), .M2(M2),
        .S1(S1), .S2(S2), .commit(commit)
    );

    time_set_unit #(
        .HOUR_MOD(12), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) u_dut12 (
        .clk(clk), .rst(rst), .adjust(adjust), .sel_field(sel_field),
        .inc(inc), .dec(dec), .load_h(load_h), .load_m(load_m),
        .load_s(load_s), .H1(H1b), .H2(H2b), .M1(M1b), .M2(M2b),
        .S1(S1b), .S2(S2b), .commit(commitb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       adj;
        logic [1:0] sel;
        logic       i;
        logic       d;
        int         lh, lm, ls;
        int         eh, em, es;
        logic       ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic a, logic [1:0] s, logic i, logic d,
                                int lh, int lm, int ls,
                                int eh, int em, int es, logic c);
        vec_t v;
        v.adj = a; v.sel = s; v.i = i; v.d = d;
        v.lh = lh; v.lm = lm; v.ls = ls;
        v.eh = eh; v.em = em; v.es = es; v.ec = c;
        vecs.push_back(v);
    endfunction

    function automatic logic [20:0] pack(int h, int m, int s, logic c);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10), c};
    endfunction

    function automatic logic [20:0] act24();
        return {H1, H2, M1, M2, S1, S2, commit};
    endfunction

    function automatic logic [20:0] act12();
        return {H1b, H2b, M1b, M2b, S1b, S2b, commitb};
    endfunction

    task automatic check(string name, logic [20:0] act, logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic a, logic [1:0] s, logic i, logic d);
        adjust    = a;
        sel_field = s;
        inc       = i;
        dec       = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam int SREP[9] = '{59, 59, 59, 59, 0, 0, 1, 1, 2};

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        load_h = 5'd13; load_m = 6'd45; load_s = 6'd30;

        // entry, single steps and exit
        add(0, 3, 0, 0, 13, 45, 30,  0,  0,  0, 0);
        add(1, 3, 0, 0, 13, 45, 30, 13, 45, 30, 0);
        add(1, 0, 1, 0, 13, 45, 30, 14, 45, 30, 0);
        add(1, 0, 0, 0, 13, 45, 30, 14, 45, 30, 0);
        add(0, 0, 0, 0, 13, 45, 30, 14, 45, 30, 1);
        add(0, 0, 1, 0, 13, 45, 30, 14, 45, 30, 0);
        add(0, 0, 1, 0, 13, 45, 30, 14, 45, 30, 0);
        add(0, 0, 0, 0, 23,  0, 58, 14, 45, 30, 0);
        // wraps
        add(1, 0, 0, 0, 23, 0, 58, 23, 0, 58, 0);
        add(1, 0, 1, 0, 23, 0, 58,  0, 0, 58, 0);
        add(1, 0, 0, 0, 23, 0, 58,  0, 0, 58, 0);
        add(1, 0, 0, 1, 23, 0, 58, 23, 0, 58, 0);
        add(1, 1, 0, 0, 23, 0, 58, 23, 0, 58, 0);
        add(1, 1, 0, 1, 23, 0, 58, 23, 59, 58, 0);
        add(1, 2, 0, 0, 23, 0, 58, 23, 59, 58, 0);
        // auto-repeat on seconds
        for (int k = 0; k < 9; k++)
            add(1, 2, 1, 0, 23, 0, 58, 23, 59, SREP[k], 0);
        add(1, 2, 0, 0, 23, 0, 58, 23, 59, 2, 0);
        // both buttons
        for (int k = 0; k < 5; k++)
            add(1, 2, 1, 1, 23, 0, 58, 23, 59, 2, 0);
        add(1, 1, 0, 0, 23, 0, 58, 23, 59, 2, 0);
        add(1, 1, 1, 0, 23, 0, 58, 23,  0, 2, 0);
        add(1, 1, 1, 0, 23, 0, 58, 23,  0, 2, 0);
        // field switch while held: suppressed until re-press
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, 0, 23, 0, 58, 23, 0, 2, 0);
        add(1, 0, 0, 0, 23, 0, 58, 23, 0, 2, 0);
        add(1, 0, 1, 0, 23, 0, 58,  0, 0, 2, 0);
        add(1, 0, 0, 0, 23, 0, 58,  0, 0, 2, 0);
        // exit, adjust re-raised during commit, clean re-entry
        add(0, 0, 0, 0, 23, 0, 58,  0, 0,  2, 1);
        add(1, 0, 1, 0, 23, 0, 58,  0, 0,  2, 0);
        add(1, 0, 0, 0, 23, 0, 58,  0, 0,  2, 0);
        add(0, 0, 0, 0, 23, 0, 58,  0, 0,  2, 0);
        add(1, 0, 0, 0, 23, 0, 58, 23, 0, 58, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", act24(), pack(0, 0, 0, 1'b0));
        check("reset12", act12(), pack(0, 0, 0, 1'b0));
        rst = 1'b0;

        foreach (vecs[n]) begin
            drive(vecs[n].adj, vecs[n].sel, vecs[n].i, vecs[n].d);
            load_h = 5'(vecs[n].lh);
            load_m = 6'(vecs[n].lm);
            load_s = 6'(vecs[n].ls);
            tick();
            check($sformatf("row%0d", n), act24(),
                  pack(vecs[n].eh, vecs[n].em, vecs[n].es, vecs[n].ec));
        end

        // reset asserted in the middle of an auto-repeat run
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        repeat (6) tick();
        check("pre_rst", act24(), pack(23, 0, 0, 1'b0));
        #2 rst = 1'b1;
        #1 check("rst_async", act24(), pack(0, 0, 0, 1'b0));
        drive(1'b0, 2'd2, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_idle", act24(), pack(0, 0, 0, 1'b0));
        tick();
        check("rst_idle2", act24(), pack(0, 0, 0, 1'b0));

        // 12-hour instance: clamp on entry, wrap both ways
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        load_h = 5'd15; load_m = 6'd7; load_s = 6'd8;
        tick();
        check("h12_clamp", act12(), pack(0, 7, 8, 1'b0));
        check("h24_load15", act24(), pack(15, 7, 8, 1'b0));
        drive(1'b1, 2'd0, 1'b0, 1'b1);
        tick();
        check("h12_dec_wrap", act12(), pack(11, 7, 8, 1'b0));
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        check("h12_inc_wrap", act12(), pack(0, 7, 8, 1'b0));
        check("h24_inc", act24(), pack(15, 7, 8, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
